mem_access: RTL
===============

# mem_access

Load/store unit sitting directly downstream of the execute stage. It consumes the ALU result as the effective address, register-file read data 2 as store data, and a decoded memory opcode. It then runs a request/acknowledge transaction on the data bus, returns the sign- or zero-extended load result, and stalls the core while the access is in flight. Lane steering, byte strobes, misalignment detection and a bus timeout are handled here, so the core never drives the data bus directly.

## Interface
- `TIMEOUT`, default 255: cycles to wait for `dbus_ack` before aborting (1..255).
- `cpu_clk`  in  1  system clock, all state on rising edge
- `cpu_rst`  in  1  synchronous reset, active-high
- `start`  in  1  request from control, sampled only in IDLE
- `mem_op`  in  4  NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8; 9..15 treated as NONE
- `alu_c`  in  32  effective byte address
- `rf_rd2`  in  32  store data (low byte/half used for SB/SH)
- `busy`  out  1  stall request to PC/register file
- `done`  out  1  one-cycle completion pulse
- `rdata`  out  32  formatted load result, valid while `done`=1
- `misalign`  out  1  with `done`: access rejected, no bus cycle
- `bus_err`  out  1  with `done`: timeout abort
- `dbus_req`  out  1  bus request, held until ack or abort
- `dbus_we`  out  1  1=store
- `dbus_addr`  out  32  word address, `{addr[31:2],2'b00}`
- `dbus_wstrb`  out  4  byte enables (stores), 0 for loads
- `dbus_wdata`  out  32  lane-replicated store data
- `dbus_ack`  in  1  transfer complete; `dbus_rdata` valid this cycle
- `dbus_rdata`  in  32  read word

## Operation
- States: IDLE, BUS, DONE, ERR.
- IDLE, `start`=1, op≠NONE, aligned: latch op, address and store data; go to BUS.
- IDLE, `start`=1, op≠NONE, misaligned: go to ERR. Alignment rules: LH/LHU/SH need `addr[0]`=0; LW/SW need `addr[1:0]`=0.
- IDLE, `start`=0 or op=NONE: stay in IDLE; no effect.
- BUS: `dbus_req`=1 and all bus outputs are driven from latched values.
  - `dbus_ack`=1: capture formatted read data; go to DONE.
  - Else, timeout counter reaches `TIMEOUT`: set `bus_err`; go to DONE.
- DONE: `done`=1 for one cycle; return to IDLE. `start` is ignored in DONE.
- ERR: `done`=1 and `misalign`=1 for one cycle; return to IDLE.
- Load formatting uses lane = `addr[1:0]`:
  - LB/LBU select byte `lane`, sign- or zero-extended to 32 bits.
  - LH/LHU select halfword `addr[1]`, sign- or zero-extended.
  - LW passes the word through.
- Store formatting:
  - SB: wdata = 4 copies of the byte; wstrb = `4'b0001<<lane`.
  - SH: 2 copies of the half; wstrb = `4'b0011<<{addr[1],1'b0}`.
  - SW: word; wstrb = `4'hF`.
- `rdata` is 0 for stores, misaligned accesses and timeouts.
- `busy` is combinational: 1 in IDLE when `start`=1 and op≠NONE; 1 in BUS; 0 in DONE, ERR and otherwise.

## Timing
- Reset (synchronous, takes effect at the next edge):
  - State → IDLE; timeout counter → 0.
  - `busy`, `done`, `misalign`, `bus_err`, `dbus_req`, `dbus_we` = 0.
  - `rdata`, `dbus_addr`, `dbus_wstrb`, `dbus_wdata` = 0.
- Reset during BUS drops `dbus_req` on the following cycle. A late `dbus_ack` then arrives in IDLE and is ignored.
- Start at cycle t → `dbus_req` at t+1. Ack at t+1 is allowed, giving `done` at t+2; an ack at t+k gives `done` at t+k+1.
- Misaligned start at t → `done`+`misalign` at t+1; `dbus_req` is never asserted.
- Timeout counter clears on entry to BUS and increments each BUS cycle without ack. If ack arrives on the same cycle the counter hits `TIMEOUT`, ack wins.
- Input changes after the start cycle have no effect; everything used is latched.
- Bus outputs are stable for the whole time `dbus_req`=1.

## Structure
- Add to the shared `param.v`: `MEM_OP_*` opcodes and `MA_ST_*` state encodings.
- Sub-module `load_ext`: combinational lane select plus sign/zero extension (in: op, lane, word; out: 32-bit result). Store steering stays inline.

## Test plan
- SW: addr 0x100, data 0xDEADBEEF, ack after 3 cycles → req with wstrb F and wdata 0xDEADBEEF; `done` 1 cycle after ack; `busy` high from the start cycle until `done`.
- LB / LBU: addr 0x203, rdata 0x80FF_0000 → LB returns 0xFFFFFF80; LBU returns 0x00000080.
- SH: addr 0x2, data 0x1234ABCD → wdata 0xABCDABCD, wstrb 4'b1100, dbus_addr 0x0.
- LW: addr 0x6 → `done` and `misalign` 1 cycle after start, `dbus_req` stays 0, `rdata`=0.
- `TIMEOUT`=4, ack never arrives → `done`+`bus_err` after the 4th BUS cycle, req dropped. A repeat run with ack on the 4th cycle completes normally without `bus_err`.
- Assert `cpu_rst` while in BUS → all outputs 0 next cycle; a later ack is ignored; a new start then completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared memory-opcode and load/store FSM definitions for the mem_access unit.
package mem_access_pkg;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        MA_ST_IDLE,
        MA_ST_BUS,
        MA_ST_DONE,
        MA_ST_ERR
    } ma_state_e;

    // Codes 9..15 behave exactly like NONE.
    function automatic logic op_valid(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lane);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return lane[0];
            MEM_OP_LW, MEM_OP_SW:             return |lane;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus request/acknowledge interface between the load/store unit and memory.
interface mem_access_if;

    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
        output dbus_ack, dbus_rdata
    );

endinterface

// File: rtl/mem_access_load_ext.sv
// Load lane select with sign/zero extension; non-load opcodes yield zero.
module load_ext
    import mem_access_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            MEM_OP_LBU: result = {24'd0, byte_sel};
            MEM_OP_LH:  result = {{16{half_sel[15]}}, half_sel};
            MEM_OP_LHU: result = {16'd0, half_sel};
            MEM_OP_LW:  result = word;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Load/store unit: runs one data-bus transaction per request and stalls the core meanwhile.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         cpu_clk,
    input  logic         cpu_rst,
    input  logic         start,
    input  logic [3:0]   mem_op,
    input  logic [31:0]  alu_c,
    input  logic [31:0]  rf_rd2,
    output logic         busy,
    output logic         done,
    output logic [31:0]  rdata,
    output logic         misalign,
    output logic         bus_err,
    mem_access_if.master dbus
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    ma_state_e   state, state_nxt;
    mem_op_e     op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [7:0]  cnt;
    logic [31:0] ext_word;
    logic        req_valid;
    logic        req_bad;
    logic        timeout_hit;

    assign req_valid   = start && op_valid(mem_op);
    assign req_bad     = op_misaligned(mem_op, alu_c[1:0]);
    assign timeout_hit = (cnt == TO_LAST);

    load_ext u_load_ext (
        .op     (op_q),
        .lane   (addr_q[1:0]),
        .word   (dbus.dbus_rdata),
        .result (ext_word)
    );

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) state <= MA_ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MA_ST_IDLE: if (req_valid) state_nxt = req_bad ? MA_ST_ERR : MA_ST_BUS;
            MA_ST_BUS:  if (dbus.dbus_ack || timeout_hit) state_nxt = MA_ST_DONE;
            default:    state_nxt = MA_ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            op_q    <= MEM_OP_NONE;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                MA_ST_IDLE: begin
                    if (req_valid && !req_bad) begin
                        op_q    <= mem_op_e'(mem_op);
                        addr_q  <= alu_c;
                        data_q  <= rf_rd2;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        cnt     <= '0;
                    end
                end
                MA_ST_BUS: begin
                    // Ack takes priority over a timeout landing on the same cycle.
                    if (dbus.dbus_ack)  rdata_q <= ext_word;
                    else if (timeout_hit) err_q <= 1'b1;
                    else                cnt   <= cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        rdata           = '0;
        misalign        = 1'b0;
        bus_err         = 1'b0;
        dbus.dbus_req   = 1'b0;
        dbus.dbus_we    = 1'b0;
        dbus.dbus_addr  = '0;
        dbus.dbus_wstrb = '0;
        dbus.dbus_wdata = '0;
        case (state)
            MA_ST_IDLE: busy = req_valid;
            MA_ST_BUS: begin
                busy           = 1'b1;
                dbus.dbus_req  = 1'b1;
                dbus.dbus_we   = op_is_store(op_q);
                dbus.dbus_addr = {addr_q[31:2], 2'b00};
                case (op_q)
                    MEM_OP_SB: begin
                        dbus.dbus_wdata = {4{data_q[7:0]}};
                        dbus.dbus_wstrb = 4'b0001 << addr_q[1:0];
                    end
                    MEM_OP_SH: begin
                        dbus.dbus_wdata = {2{data_q[15:0]}};
                        dbus.dbus_wstrb = 4'b0011 << {addr_q[1], 1'b0};
                    end
                    MEM_OP_SW: begin
                        dbus.dbus_wdata = data_q;
                        dbus.dbus_wstrb = 4'hF;
                    end
                    default: ;
                endcase
            end
            MA_ST_DONE: begin
                done    = 1'b1;
                rdata   = rdata_q;
                bus_err = err_q;
            end
            MA_ST_ERR: begin
                done     = 1'b1;
                misalign = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
